keypad_key_capture: RTL and testbench

//  Row-side stage of the 4x4 keypad scanner; sits beside the 2-bit column counter.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_key_capture_if.sv | 19 +
 rtl/keypad_key_capture_sync_2ff.sv | 25 ++
 rtl/keypad_key_capture.sv | 161 ++++++++++++++++
 tb/tb_keypad_key_capture.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad row-capture stage.
// Holds the scan state enum, key code type and the row priority encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    typedef logic [3:0] key_code_t;

    // Rows are active-low; the lowest-numbered low row wins.
    function automatic logic [1:0] row_encode(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        priority case (1'b1)
            !rows_n[0]: idx = 2'd0;
            !rows_n[1]: idx = 2'd1;
            !rows_n[2]: idx = 2'd2;
            !rows_n[3]: idx = 2'd3;
            default:    idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_key_capture_if.sv
// Key output bundle: key_code with its single-cycle key_valid strobe.
// master = capture stage (drives), slave = display/decoder (consumes).
interface keypad_key_capture_if;
    import keypad_pkg::*;

    key_code_t key_code;
    logic      key_valid;

    modport master (
        output key_code,
        output key_valid
    );

    modport slave (
        input key_code,
        input key_valid
    );

endinterface

// File: rtl/keypad_key_capture_sync_2ff.sv
// Double-flop synchronizer for the asynchronous keypad row lines.
// Ports: clk, reset (async, high), d (async in), q (synced out, resets to all ones).
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Reset to ones so released (high) rows are seen out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_key_capture.sv
// Row-side keypad scanner stage: paces the column counter, debounces, strobes key codes.
// Ports: clk, reset, col_idx (counter q), rows_n (async, active-low), inhibit, key (master).
module keypad_key_capture
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int SCAN_DIV        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  col_idx,
    input  logic [3:0]                  rows_n,
    output logic                        inhibit,
    keypad_key_capture_if.master        key
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DIV_ONE  = CW'(1);

    logic [3:0]    rows_s;
    logic          row_act;
    logic [1:0]    row_idx;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] div_cnt;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_inc;
    logic [1:0]    row_l;
    logic [1:0]    col_l;
    key_code_t     key_code_q;
    logic          key_valid_q;
    logic          div_tick;
    logic          deb_done;
    logic          row_l_low;

    sync_2ff #(
        .WIDTH(4)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rows_n),
        .q    (rows_s)
    );

    assign row_act   = |(~rows_s);
    assign row_idx   = row_encode(rows_s);
    assign div_tick  = (div_cnt == DIV_LAST);
    assign deb_done  = (deb_cnt == DEB_LAST);
    assign row_l_low = ~rows_s[row_l];
    // Saturate instead of wrapping so a stuck count can never alias.
    assign deb_inc   = (deb_cnt == '1) ? deb_cnt : deb_cnt + DEB_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SCAN: begin
                // Rows only trusted on the last div cycle, once the column settled.
                if (div_tick && row_act) begin
                    state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!row_l_low) begin
                    state_nxt = SCAN;
                end else if (deb_done) begin
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (!row_act) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!row_act && deb_done) begin
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_comb begin
        inhibit = 1'b1;
        if (state == SCAN && div_tick && !row_act) begin
            inhibit = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            deb_cnt     <= '0;
            row_l       <= 2'd0;
            col_l       <= 2'd0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (div_tick && row_act) begin
                        row_l   <= row_idx;
                        col_l   <= col_idx;
                        deb_cnt <= '0;
                        div_cnt <= '0;
                    end else if (div_tick) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                DEBOUNCE: begin
                    div_cnt <= '0;
                    if (row_l_low) begin
                        deb_cnt <= deb_inc;
                        if (deb_done) begin
                            key_code_q  <= {row_l, col_l};
                            key_valid_q <= 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    div_cnt <= '0;
                    if (!row_act) begin
                        deb_cnt <= '0;
                    end
                end
                RELEASE: begin
                    div_cnt <= '0;
                    if (row_act) begin
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_inc;
                    end
                end
                default: begin
                    div_cnt <= '0;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

    assign key.key_code  = key_code_q;
    assign key.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_key_capture.sv
// Closed-loop bench: column counter + keypad model around keypad_key_capture.
// Scoreboard queue of expected key codes, drained by a strobe monitor.
module tb_keypad_key_capture;
    import keypad_pkg::*;

    localparam int DEB = 8;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] col_idx;
    logic [3:0] rows_n;
    logic       inhibit;
    logic [3:0] kp_mask;
    logic [1:0] kp_col;

    int        checks   = 0;
    int        failures = 0;
    key_code_t exp_q[$];
    key_code_t exp_last = '0;

    keypad_key_capture_if kif ();

    keypad_key_capture #(
        .DEBOUNCE_CYCLES(DEB),
        .SCAN_DIV       (DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .col_idx(col_idx),
        .rows_n (rows_n),
        .inhibit(inhibit),
        .key    (kif)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_idx <= 2'd0;
        end else if (!inhibit) begin
            col_idx <= col_idx + 2'd1;
        end
    end

    assign rows_n = (kp_mask != 4'h0 && col_idx == kp_col) ? ~kp_mask : 4'hF;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic key_code_t ref_code(input logic [3:0] mask,
                                           input logic [1:0] col);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) return {2'(i), col};
        end
        return {2'b00, col};
    endfunction

    always @(negedge clk) begin
        if (!reset && kif.key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got code %0d expected none",
                         kif.key_code);
            end else begin
                chk("key_code", kif.key_code, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge right after the counter stepped onto col.
    task automatic wait_col_enter(input logic [1:0] col);
        logic [1:0] prevc;
        bit ok;
        prevc = col - 2'd1;
        ok = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (!inhibit && col_idx == prevc) begin
                @(negedge clk);
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL col_enter_timeout: got none expected col %0d", col);
        end
    endtask

    task automatic wait_strobe(input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (kif.key_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL strobe_timeout: got none expected key_valid");
        end
    endtask

    task automatic count_lows(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (!inhibit) lows++;
        end
    endtask

    task automatic first_low(input int budget, output int idx);
        idx = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (!inhibit) begin
                idx = k;
                break;
            end
        end
    endtask

    task automatic clean_press(input logic [3:0] mask, input logic [1:0] col,
                               input int hold, input int gap);
        exp_q.push_back(ref_code(mask, col));
        exp_last = ref_code(mask, col);
        kp_col  = col;
        kp_mask = mask;
        cyc(hold);
        kp_mask = 4'h0;
        cyc(gap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int idx;
        int prev_low;
        bit need_col;
        logic [1:0] ecol;

        reset   = 1'b1;
        kp_mask = 4'h0;
        kp_col  = 2'd0;
        cyc(3);
        chk("reset_inhibit", inhibit, 1);
        chk("reset_key_code", kif.key_code, 0);
        chk("reset_key_valid", kif.key_valid, 0);
        reset = 1'b0;

        // Idle cadence: one inhibit low per DIV cycles, column steps by one.
        chk("col_after_reset", col_idx, 0);
        lows = 0;
        prev_low = -1;
        need_col = 0;
        ecol = 2'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (need_col) begin
                chk("col_step", col_idx, ecol);
                need_col = 0;
            end
            if (!inhibit) begin
                lows++;
                if (prev_low >= 0) chk("inhibit_gap", i - prev_low, DIV);
                prev_low = i;
                ecol = col_idx + 2'd1;
                need_col = 1;
            end
        end
        chk("idle_inhibit_lows", lows, 5);

        // Row 2 / col 1, held, then released with two glitches.
        exp_q.push_back(ref_code(4'b0100, 2'd1));
        exp_last = ref_code(4'b0100, 2'd1);
        kp_col  = 2'd1;
        kp_mask = 4'b0100;
        wait_strobe(60);
        count_lows(100, lows);
        chk("hold_inhibit_lows", lows, 0);
        kp_mask = 4'h0;
        cyc(3);
        kp_mask = 4'b0100;
        cyc(1);
        kp_mask = 4'h0;
        cyc(3);
        kp_mask = 4'b0100;
        cyc(1);
        kp_mask = 4'h0;
        first_low(30, idx);
        chk("release_scan_reentry", idx, 13);
        cyc(10);

        // Row 0 / col 3 bounce: three debounce cycles low, then high.
        wait_col_enter(2'd3);
        kp_col  = 2'd3;
        kp_mask = 4'b0001;
        count_lows(5, lows);
        chk("bounce_captured", lows, 0);
        kp_mask = 4'h0;
        first_low(20, idx);
        chk("bounce_scan_resume", idx, 6);
        cyc(10);

        // Rows 1 and 3 together on col 2: lowest row wins.
        clean_press(4'b1010, 2'd2, 50, 30);

        // Reset while the debounce count sits at 5.
        wait_col_enter(2'd0);
        kp_col  = 2'd0;
        kp_mask = 4'b1000;
        cyc(9);
        reset   = 1'b1;
        kp_mask = 4'h0;
        cyc(1);
        chk("midreset_inhibit", inhibit, 1);
        chk("midreset_key_code", kif.key_code, 0);
        chk("midreset_key_valid", kif.key_valid, 0);
        exp_last = '0;
        cyc(1);
        reset = 1'b0;
        cyc(30);

        // Randomised mix of clean presses and short bounces.
        for (int t = 0; t < 16; t++) begin
            logic [3:0] m;
            logic [1:0] c;
            m = 4'($urandom_range(1, 15));
            c = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                kp_col  = c;
                kp_mask = m;
                cyc($urandom_range(1, 3));
                kp_mask = 4'h0;
                cyc($urandom_range(25, 40));
            end else begin
                clean_press(m, c, $urandom_range(40, 90),
                            $urandom_range(25, 40));
            end
        end

        cyc(20);
        chk("pending_expected", exp_q.size(), 0);
        chk("key_code_held", kif.key_code, exp_last);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
